// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the display-SPI receive path.
package spi_rx_pkg;

    typedef enum logic [1:0] {StWaitIdle, StIdle, StShift} state_e;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned ENTRY_WIDTH   = 9;

    // FIFO entry layout: {dc, data[7:0]}
    typedef logic [ENTRY_WIDTH-1:0] entry_t;

endpackage

// File: rtl/spi_rx_ip_if.sv
// Valid/ready read port carrying received bytes and their dc tag.
interface spi_rx_ip_if;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_dc, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_dc, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO for received {dc, data} entries.
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   push_ok
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_ip.sv
// SPI mode-0 receiver/monitor for the 4-wire display bus (cs, dc, scl, sda).
// Synchronises the bus, deserialises MSB-first bytes and queues them with their dc tag.
module spi_rx_ip
    import spi_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cs,
    input  logic              dc,
    input  logic              scl,
    input  logic              sda,
    input  logic              clear_err,
    spi_rx_ip_if.master       rx,
    output logic              frame_active,
    output logic [7:0]        byte_count,
    output logic              overflow,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

    logic [SYNC_STAGES-1:0] cs_q, dc_q, scl_q, sda_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   cs_d_q, scl_d_q;
    logic                   cs_s, dc_s, scl_s, sda_s;
    logic                   scl_rise, cs_fall, cs_rise, primed;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [7:0]       shift_q;
    logic             push_q;
    entry_t           entry_q;
    logic             start, shift_en, last_bit;

    entry_t head;
    logic   full, empty, push_ok;

    assign cs_s  = cs_q[SYNC_STAGES-1];
    assign dc_s  = dc_q[SYNC_STAGES-1];
    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_d_q;
    assign cs_fall  = ~cs_s & cs_d_q;
    assign cs_rise  = cs_s & ~cs_d_q;
    // Reset preloads the chain with idle 1s; only trust cs_s once real samples have arrived.
    assign primed   = fill_q[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_q    <= '1;
            dc_q    <= '1;
            scl_q   <= '1;
            sda_q   <= '1;
            cs_d_q  <= 1'b1;
            scl_d_q <= 1'b1;
            fill_q  <= '0;
        end else begin
            cs_q    <= {cs_q[SYNC_STAGES-2:0], cs};
            dc_q    <= {dc_q[SYNC_STAGES-2:0], dc};
            scl_q   <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q   <= {sda_q[SYNC_STAGES-2:0], sda};
            cs_d_q  <= cs_s;
            scl_d_q <= scl_s;
            fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StWaitIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitIdle: if (primed && cs_s)      state_d = StIdle;
            StIdle:     if (cs_fall && enable)   state_d = StShift;
            StShift:    if (cs_rise || !enable)  state_d = StIdle;
            default:                             state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        frame_active = (state_q == StShift);
    end

    assign start    = (state_q == StIdle) && (state_d == StShift);
    assign shift_en = (state_q == StShift) && (state_d == StShift) && scl_rise;
    assign last_bit = shift_en && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            entry_q    <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (start || (state_d != StShift)) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (shift_en) begin
                shift_q <= {shift_q[6:0], sda_s};
            end
            push_q <= last_bit;
            if (last_bit) begin
                entry_q <= {dc_s, shift_q[6:0], sda_s};
            end

            if (start) begin
                byte_count <= '0;
            end else if (push_ok && (byte_count != 8'hFF)) begin
                byte_count <= byte_count + 8'd1;
            end

            // Set beats clear when both land on the same edge.
            if (push_q && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if ((state_q == StShift) && cs_rise && (bit_cnt_q != '0)) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    spi_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (entry_q),
        .pop       (rx.rx_ready),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .push_ok   (push_ok)
    );

    assign rx.rx_data  = head[7:0];
    assign rx.rx_dc    = head[8];
    assign rx.rx_valid = ~empty;

endmodule

// File: tb/tb_spi_rx_ip.sv
// Directed bench for spi_rx_ip: drives mode-0 frames and checks the FIFO read port and flags.
module tb_spi_rx_ip;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       cs = 1'b1;
    logic       dc = 1'b0;
    logic       scl = 1'b0;
    logic       sda = 1'b0;
    logic       clear_err = 1'b0;
    logic       frame_active;
    logic [7:0] byte_count;
    logic       overflow;
    logic       frame_err;

    int vec  = 0;
    int miss = 0;
    int base;

    logic [8:0] log_q[$];

    spi_rx_ip_if rx_if ();

    spi_rx_ip #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cs           (cs),
        .dc           (dc),
        .scl          (scl),
        .sda          (sda),
        .clear_err    (clear_err),
        .rx           (rx_if),
        .frame_active (frame_active),
        .byte_count   (byte_count),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Record every handshake seen one half-cycle before the popping edge.
    always @(negedge clk) begin
        if (rx_if.rx_valid && rx_if.rx_ready) log_q.push_back({rx_if.rx_dc, rx_if.rx_data});
    end

    task automatic send_bit(input logic b);
        sda = b;
        #50 scl = 1'b1;
        #50 scl = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    task automatic frame_start(input logic d);
        @(negedge clk);
        dc = d;
        cs = 1'b0;
        #50;
    endtask

    task automatic frame_end();
        #50 cs = 1'b1;
        #100;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 rx_if.rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
    endtask

    task automatic test_reset();
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data} !== 10'h0) begin
            miss++;
            $display("FAIL reset_port: got %h want 000", {rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data});
        end
        vec++;
        if ({frame_active, byte_count, overflow, frame_err} !== 11'h0) begin
            miss++;
            $display("FAIL reset_status: got %h want 000",
                     {frame_active, byte_count, overflow, frame_err});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_single();
        rx_if.rx_ready = 1'b1;
        base = log_q.size();
        frame_start(1'b0);
        send_bits(8'h11, 7);
        vec++;
        if (frame_active !== 1'b1) begin
            miss++;
            $display("FAIL single_active: got %b want 1", frame_active);
        end
        sda = 1'b1;
        #50 scl = 1'b1;
        #30;
        vec++;
        if (rx_if.rx_valid !== 1'b0) begin
            miss++;
            $display("FAIL latency_edge3: got %b want 0", rx_if.rx_valid);
        end
        #10;
        vec++;
        if ({rx_if.rx_valid, rx_if.rx_data} !== 9'h111) begin
            miss++;
            $display("FAIL latency_edge4: got %h want 111", {rx_if.rx_valid, rx_if.rx_data});
        end
        #10 scl = 1'b0;
        frame_end();
        vec++;
        if (log_q.size() - base != 1 || log_q[base] !== 9'h011) begin
            miss++;
            $display("FAIL single_pop: got n=%0d %h want n=1 011", log_q.size() - base,
                     log_q[log_q.size()-1]);
        end
        vec++;
        if ({byte_count, overflow, frame_err, frame_active, rx_if.rx_valid} !== 12'h010) begin
            miss++;
            $display("FAIL single_status: got %h want 010",
                     {byte_count, overflow, frame_err, frame_active, rx_if.rx_valid});
        end
    endtask

    task automatic test_back_to_back();
        rx_if.rx_ready = 1'b0;
        base = log_q.size();
        frame_start(1'b1);
        send_bits(8'h29, 8);
        send_bits(8'hA5, 8);
        frame_end();
        vec++;
        if ({rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, byte_count} !== 18'h3_2902) begin
            miss++;
            $display("FAIL b2b_head: got %h want 32902",
                     {rx_if.rx_valid, rx_if.rx_dc, rx_if.rx_data, byte_count});
        end
        pop_n(2);
        vec++;
        if (log_q.size() - base != 2 || log_q[base] !== 9'h129 || log_q[base+1] !== 9'h1A5) begin
            miss++;
            $display("FAIL b2b_order: got n=%0d want 129,1a5", log_q.size() - base);
        end
        vec++;
        if (rx_if.rx_valid !== 1'b0) begin
            miss++;
            $display("FAIL b2b_drain: got valid=%b want 0", rx_if.rx_valid);
        end
    endtask

    task automatic test_overflow();
        rx_if.rx_ready = 1'b0;
        base = log_q.size();
        frame_start(1'b0);
        for (int b = 1; b <= 6; b++) send_bits(8'(b), 8);
        frame_end();
        vec++;
        if ({overflow, byte_count, rx_if.rx_data} !== 17'h1_0401) begin
            miss++;
            $display("FAIL ovf_set: got %h want 10401", {overflow, byte_count, rx_if.rx_data});
        end
        pulse_clear();
        vec++;
        if (overflow !== 1'b0) begin
            miss++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        pop_n(4);
        vec++;
        if (log_q.size() - base != 4) begin
            miss++;
            $display("FAIL ovf_count: got %0d want 4", log_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (log_q[base+i] !== 9'(i + 1)) begin
                    miss++;
                    $display("FAIL ovf_entry%0d: got %h want %h", i, log_q[base+i], 9'(i + 1));
                end
            end
        end
    endtask

    task automatic test_frame_err();
        rx_if.rx_ready = 1'b1;
        base = log_q.size();
        frame_start(1'b0);
        send_bits(8'hFF, 5);
        frame_end();
        vec++;
        if ({frame_err, frame_active, rx_if.rx_valid, byte_count} !== 11'h400) begin
            miss++;
            $display("FAIL ferr_set: got %h want 400",
                     {frame_err, frame_active, rx_if.rx_valid, byte_count});
        end
        pulse_clear();
        vec++;
        if (frame_err !== 1'b0) begin
            miss++;
            $display("FAIL ferr_clear: got %b want 0", frame_err);
        end
        frame_start(1'b0);
        send_bits(8'h3C, 8);
        frame_end();
        vec++;
        if (log_q.size() - base != 1 || log_q[base] !== 9'h03C || frame_err !== 1'b0) begin
            miss++;
            $display("FAIL ferr_next: got n=%0d ferr=%b want n=1 03c ferr=0",
                     log_q.size() - base, frame_err);
        end
    endtask

    task automatic test_reset_mid();
        rx_if.rx_ready = 1'b1;
        base = log_q.size();
        frame_start(1'b1);
        send_bits(8'hC3, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #50;
        vec++;
        if ({frame_active, rx_if.rx_valid, frame_err, byte_count} !== 11'h000 ||
            log_q.size() != base) begin
            miss++;
            $display("FAIL rstmid_drop: got %h n=%0d want 000 n=0",
                     {frame_active, rx_if.rx_valid, frame_err, byte_count}, log_q.size() - base);
        end
        cs = 1'b1;
        #100;
        frame_start(1'b1);
        send_bits(8'hC3, 8);
        frame_end();
        vec++;
        if (log_q.size() - base != 1 || log_q[base] !== 9'h1C3 || byte_count !== 8'd1) begin
            miss++;
            $display("FAIL rstmid_next: got n=%0d cnt=%0d want n=1 1c3 cnt=1",
                     log_q.size() - base, byte_count);
        end
    endtask

    task automatic test_full_pop();
        rx_if.rx_ready = 1'b0;
        base = log_q.size();
        frame_start(1'b0);
        for (int b = 8'h41; b <= 8'h44; b++) send_bits(8'(b), 8);
        send_bits(8'h45, 7);
        sda = 1'b1;
        #50 scl = 1'b1;
        // Hold ready across only the edge that pushes the 5th byte.
        #26 rx_if.rx_ready = 1'b1;
        #10 rx_if.rx_ready = 1'b0;
        #14 scl = 1'b0;
        frame_end();
        vec++;
        if ({overflow, byte_count, rx_if.rx_data} !== 17'h0_0542) begin
            miss++;
            $display("FAIL fullpop_status: got %h want 00542", {overflow, byte_count, rx_if.rx_data});
        end
        pop_n(4);
        vec++;
        if (log_q.size() - base != 5) begin
            miss++;
            $display("FAIL fullpop_count: got %0d want 5", log_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                vec++;
                if (log_q[base+i] !== 9'(8'h41 + i)) begin
                    miss++;
                    $display("FAIL fullpop_entry%0d: got %h want %h", i, log_q[base+i],
                             9'(8'h41 + i));
                end
            end
        end
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        test_full_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
